fp32_to_fixed: RTL and testbench
================================

FP32_TO_FIXED -- requirements
Module: fp32_to_fixed

Interface
REQ-001 SHALL have parameter FRAC_BITS, default 16: number of fraction bits of the signed 32-bit two's-complement output; legal range 0..30.
REQ-002 SHALL have port clk_in, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_in, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port valid_in, input, 1 bit: a_in holds a valid operand this cycle.
REQ-005 SHALL have port a_in, input, 32 bits: IEEE-754 binary32 operand.
REQ-006 SHALL have port valid_out, output, 1 bit: fixed_out holds a valid result this cycle.
REQ-007 SHALL have port fixed_out, output, 32 bits: signed fixed-point result, Q(31-FRAC_BITS).FRAC_BITS.
REQ-008 SHALL have port overflow_out, output, 1 bit, present only when FP32_TO_FIXED_OVF_EN is defined: result saturated or operand was NaN.

Function
REQ-009 SHALL be fully pipelined: one operand accepted every cycle, no backpressure, no stalls.
REQ-010 SHALL produce each result exactly 4 cycles after its valid_in sample; valid_out SHALL be valid_in delayed 4 cycles.
REQ-011 Stage 1 SHALL register sign, biased exponent E, 24-bit mantissa M = {E!=0, a_in[22:0]}, and class flags zero/denormal (E==0), special (E==255).
REQ-012 Stage 2 SHALL compute shift S = E - 150 + FRAC_BITS as a signed 10-bit value; S>=0 left-shifts M; S<0 right-shifts M, keeping guard bit and sticky OR of all discarded lower bits; right shifts of 25 or more give magnitude 0, guard 0, sticky = (M!=0).
REQ-013 Stage 2 SHALL flag pre-overflow when E - 127 >= 31 - FRAC_BITS.
REQ-014 Stage 3 SHALL round magnitude to nearest, ties to even: increment when guard=1 and (sticky=1 or LSB=1).
REQ-015 Stage 4 SHALL apply sign by two's-complement negation and saturate: positive overflow -> 32'h7FFFFFFF, negative overflow -> 32'h80000000.
REQ-016 Negative magnitude exactly 2^31 (e.g. -2^(31-FRAC_BITS)) SHALL yield 32'h80000000 without overflow; positive magnitude >= 2^31 after rounding SHALL saturate.
REQ-017 Zero and denormal operands SHALL yield 32'h00000000 with no overflow, sign ignored.
REQ-018 +Inf SHALL yield 32'h7FFFFFFF, -Inf 32'h80000000, NaN 32'h00000000; all three flag overflow.
REQ-019 fixed_out SHALL hold its last value while valid_out is low; contents with valid_out low are don't-care to consumers.

Reset
REQ-020 While rst_in is low at a clock edge, all valid pipeline stages, valid_out, fixed_out and overflow_out SHALL clear to 0 on that edge.
REQ-021 valid_in sampled while rst_in is low SHALL be discarded; operands in flight at reset SHALL never emerge.
REQ-022 First valid_out after release SHALL come 4 cycles after the first valid_in sampled with rst_in high.

Configuration
REQ-023 Macro FP32_TO_FIXED_OVF_EN defined: overflow_out port and its 4-stage flag pipeline SHALL exist, asserting with the matching valid_out per REQ-013/015/016/018.
REQ-024 Macro FP32_TO_FIXED_OVF_EN undefined: overflow_out port and flag logic SHALL be absent; fixed_out and saturation behaviour SHALL be identical.

Verification (FRAC_BITS=16, FP32_TO_FIXED_OVF_EN defined)
REQ-025 a_in=32'h3F800000 (1.0), valid_in 1 cycle -> 4 cycles later valid_out=1, fixed_out=32'h00010000, overflow_out=0.
REQ-026 a_in=32'hC0200000 (-2.5) -> fixed_out=32'hFFFD8000; a_in=32'h37C00000 (1.5 LSB) -> 32'h00000002; a_in=32'h37000000 (0.5 LSB) -> 32'h00000000.
REQ-027 a_in=32'h471C4000 (40000.0) -> 32'h7FFFFFFF, overflow 1; 32'hC7000000 (-32768.0) -> 32'h80000000, overflow 0; 32'h7FC00000 (NaN) -> 32'h00000000, overflow 1.
REQ-028 10 back-to-back operands 1.0..10.0 -> 10 consecutive valid_out cycles, 32'h00010000..32'h000A0000 in order.
REQ-029 rst_in low for 1 cycle while 3 operands in flight -> no valid_out for those; operand issued after release appears exactly 4 cycles later.

Source files
------------

// File: rtl/fp32_to_fixed.sv
// fp32_to_fixed: 4-stage pipelined IEEE-754 binary32 to signed Q(31-FRAC_BITS).FRAC_BITS
// converter, round-to-nearest-even with saturation. Define FP32_TO_FIXED_OVF_EN to add overflow_out.
module fp32_to_fixed #(
    parameter int FRAC_BITS = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        valid_in,
    input  logic [31:0] a_in,
    output logic        valid_out,
    output logic [31:0] fixed_out
`ifdef FP32_TO_FIXED_OVF_EN
    ,
    output logic        overflow_out
`endif
);

    // Biased exponent at which |value| reaches 2^31 output LSBs.
    localparam logic [9:0] OVF_EXP    = 10'(158 - FRAC_BITS);
    localparam logic [9:0] BIAS_SHIFT = 10'd150;
    localparam logic [9:0] FRAC_W     = 10'(FRAC_BITS);

    genvar gi;

    logic [3:0] valid_reg;
    logic [3:0] valid_next;

    assign valid_next[0] = valid_in;
    generate
        for (gi = 1; gi < 4; gi++) begin : g_valid
            assign valid_next[gi] = valid_reg[gi-1];
        end
    endgenerate

    // Stage 1: field split and classification
    logic        s1_sign_reg;
    logic        s1_zero_reg;
    logic        s1_special_reg;
    logic [7:0]  s1_exp_reg;
    logic [23:0] s1_mant_reg;

    always_ff @(posedge clk_in) begin
        if (valid_in) begin
            s1_sign_reg    <= a_in[31];
            s1_exp_reg     <= a_in[30:23];
            s1_mant_reg    <= {|a_in[30:23], a_in[22:0]};
            s1_zero_reg    <= (a_in[30:23] == 8'h00);
            s1_special_reg <= (a_in[30:23] == 8'hFF);
        end
    end

    // Stage 2: align mantissa to the output binary point
    logic [9:0]  exp_ext;
    logic [9:0]  shift_s;
    logic [9:0]  rsh_amt;
    logic [48:0] rsh_ext;
    logic [31:0] s2_mag_next;
    logic        s2_guard_next;
    logic        s2_sticky_next;
    logic        s2_preovf_next;
    logic        s2_min_neg_next;
    logic        s2_nan_next;

    always_comb begin
        exp_ext         = {2'b00, s1_exp_reg};
        shift_s         = exp_ext - BIAS_SHIFT + FRAC_W;
        rsh_amt         = BIAS_SHIFT - exp_ext - FRAC_W;
        rsh_ext         = {s1_mant_reg, 25'd0} >> rsh_amt;
        s2_mag_next     = '0;
        s2_guard_next   = 1'b0;
        s2_sticky_next  = 1'b0;
        if (!s1_zero_reg) begin
            if (!shift_s[9]) begin
                // Exact for shifts up to 8; anything larger is already pre-overflow.
                s2_mag_next = {8'd0, s1_mant_reg} << shift_s;
            end else if (rsh_amt >= 10'd25) begin
                s2_sticky_next = |s1_mant_reg;
            end else begin
                s2_mag_next    = {8'd0, rsh_ext[48:25]};
                s2_guard_next  = rsh_ext[24];
                s2_sticky_next = |rsh_ext[23:0];
            end
        end
        s2_preovf_next  = (exp_ext >= OVF_EXP);
        // -2^31 exactly is representable even though its exponent pre-overflows.
        s2_min_neg_next = s1_sign_reg && (exp_ext == OVF_EXP) && (s1_mant_reg[22:0] == 23'd0);
        s2_nan_next     = s1_special_reg && (s1_mant_reg[22:0] != 23'd0);
    end

    logic        s2_sign_reg;
    logic        s2_special_reg;
    logic        s2_nan_reg;
    logic        s2_preovf_reg;
    logic        s2_min_neg_reg;
    logic        s2_guard_reg;
    logic        s2_sticky_reg;
    logic [31:0] s2_mag_reg;

    always_ff @(posedge clk_in) begin
        if (valid_reg[0]) begin
            s2_sign_reg    <= s1_sign_reg;
            s2_special_reg <= s1_special_reg;
            s2_nan_reg     <= s2_nan_next;
            s2_preovf_reg  <= s2_preovf_next;
            s2_min_neg_reg <= s2_min_neg_next;
            s2_guard_reg   <= s2_guard_next;
            s2_sticky_reg  <= s2_sticky_next;
            s2_mag_reg     <= s2_mag_next;
        end
    end

    // Stage 3: round to nearest, ties to even
    logic        round_up;
    logic [32:0] s3_mag_next;

    assign round_up    = s2_guard_reg && (s2_sticky_reg || s2_mag_reg[0]);
    assign s3_mag_next = {1'b0, s2_mag_reg} + {32'd0, round_up};

    logic        s3_sign_reg;
    logic        s3_special_reg;
    logic        s3_nan_reg;
    logic        s3_preovf_reg;
    logic        s3_min_neg_reg;
    logic [32:0] s3_mag_reg;

    always_ff @(posedge clk_in) begin
        if (valid_reg[1]) begin
            s3_sign_reg    <= s2_sign_reg;
            s3_special_reg <= s2_special_reg;
            s3_nan_reg     <= s2_nan_reg;
            s3_preovf_reg  <= s2_preovf_reg;
            s3_min_neg_reg <= s2_min_neg_reg;
            s3_mag_reg     <= s3_mag_next;
        end
    end

    // Stage 4: sign application and saturation
    logic        sat_next;
    logic [31:0] result_next;

    always_comb begin
        sat_next    = s3_preovf_reg || (s3_mag_reg[32:31] != 2'b00);
        result_next = s3_mag_reg[31:0];
        if (s3_nan_reg) begin
            result_next = 32'h0000_0000;
        end else if (s3_special_reg || (sat_next && !s3_min_neg_reg)) begin
            result_next = s3_sign_reg ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else if (s3_min_neg_reg) begin
            result_next = 32'h8000_0000;
        end else if (s3_sign_reg) begin
            result_next = ~s3_mag_reg[31:0] + 32'd1;
        end
    end

    logic [31:0] fixed_reg;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            valid_reg <= '0;
            fixed_reg <= '0;
        end else begin
            valid_reg <= valid_next;
            if (valid_reg[2]) begin
                fixed_reg <= result_next;
            end
        end
    end

    assign valid_out = valid_reg[3];
    assign fixed_out = fixed_reg;

`ifdef FP32_TO_FIXED_OVF_EN
    logic ovf_next;
    logic ovf_reg;

    assign ovf_next = s3_nan_reg || s3_special_reg || (sat_next && !s3_min_neg_reg);

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            ovf_reg <= 1'b0;
        end else if (valid_reg[2]) begin
            ovf_reg <= ovf_next;
        end
    end

    assign overflow_out = ovf_reg;
`endif

endmodule

// File: tb/tb_fp32_to_fixed.sv
// Directed-vector bench for fp32_to_fixed (FRAC_BITS=16); overflow_out is checked when
// FP32_TO_FIXED_OVF_EN is defined.
module tb_fp32_to_fixed;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        valid_in;
    logic [31:0] a_in;
    logic        valid_out;
    logic [31:0] fixed_out;
`ifdef FP32_TO_FIXED_OVF_EN
    logic        overflow_out;
`endif

    fp32_to_fixed #(.FRAC_BITS(16)) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .valid_in  (valid_in),
        .a_in      (a_in),
        .valid_out (valid_out),
        .fixed_out (fixed_out)
`ifdef FP32_TO_FIXED_OVF_EN
        ,
        .overflow_out(overflow_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [31:0] f;
        logic        o;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] last_f = 32'h0;

    localparam int NV = 23;
    logic [31:0] vec_a [NV] = '{
        32'h3F800000, 32'hC0200000, 32'h37C00000, 32'h37000000, 32'h471C4000,
        32'hC7000000, 32'h7FC00000, 32'h7F800000, 32'hFF800000, 32'h80000000,
        32'h00000001, 32'h80400000, 32'h38200000, 32'h37400000, 32'hB7C00000,
        32'h46FFFE00, 32'hC7000080, 32'h47000000, 32'hBF800000, 32'h00800000,
        32'h3FC00000, 32'h7F7FFFFF, 32'h38600000};
    logic [31:0] vec_f [NV] = '{
        32'h00010000, 32'hFFFD8000, 32'h00000002, 32'h00000000, 32'h7FFFFFFF,
        32'h80000000, 32'h00000000, 32'h7FFFFFFF, 32'h80000000, 32'h00000000,
        32'h00000000, 32'h00000000, 32'h00000002, 32'h00000001, 32'hFFFFFFFE,
        32'h7FFF0000, 32'h80000000, 32'h7FFFFFFF, 32'hFFFF0000, 32'h00000000,
        32'h00018000, 32'h7FFFFFFF, 32'h00000004};
    logic        vec_o [NV] = '{
        1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
        1'b0, 1'b1, 1'b1, 1'b1, 1'b0,
        1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
        1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
        1'b0, 1'b1, 1'b0};
    logic [31:0] ramp_a [10] = '{
        32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
        32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000, 32'h41200000};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic push_exp(input logic [31:0] f, input logic o);
        exp_t e;
        e.f   = f;
        e.o   = o;
        e.due = cyc + 4;
        exp_q.push_back(e);
        last_f = f;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] f, input logic o);
        @(posedge clk_in);
        #1;
        valid_in = 1'b1;
        a_in     = a;
        push_exp(f, o);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
            valid_in = 1'b0;
            a_in     = 32'hDEADBEEF;
        end
    endtask

    always @(posedge clk_in) cyc <= cyc + 1;

    // Output monitor: every valid_out must match the oldest outstanding operand on its due cycle.
    always @(posedge clk_in) begin
        #1;
        if (exp_q.size() > 0 && !valid_out && exp_q[0].due <= cyc) begin
            check("missing_valid", {31'b0, valid_out}, 32'd1);
            void'(exp_q.pop_front());
        end else if (valid_out) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", {31'b0, valid_out}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("latency", 32'(cyc), 32'(mon_e.due));
                check("fixed", fixed_out, mon_e.f);
`ifdef FP32_TO_FIXED_OVF_EN
                check("overflow", {31'b0, overflow_out}, {31'b0, mon_e.o});
`endif
                $display("out cycle=%0d fixed=%h expected=%h ovf_expected=%0b", cyc, fixed_out, mon_e.f, mon_e.o);
            end
        end
    end

    initial begin
        rst_in   = 1'b0;
        valid_in = 1'b1;
        a_in     = 32'h3F800000;
        repeat (3) @(posedge clk_in);
        #1;
        check("reset_valid", {31'b0, valid_out}, 32'd0);
        check("reset_fixed", fixed_out, 32'h0);
`ifdef FP32_TO_FIXED_OVF_EN
        check("reset_ovf", {31'b0, overflow_out}, 32'd0);
`endif
        rst_in   = 1'b1;
        valid_in = 1'b0;
        idle(2);

        // Lone operand, then the directed table back to back
        send(vec_a[0], vec_f[0], vec_o[0]);
        idle(6);
        for (int i = 1; i < NV; i++) begin
            send(vec_a[i], vec_f[i], vec_o[i]);
        end
        idle(6);

        for (int i = 0; i < 10; i++) begin
            send(ramp_a[i], 32'(i + 1) << 16, 1'b0);
        end
        idle(6);

        // Three operands in flight when a one-cycle reset hits
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_in);
            #1;
            valid_in = 1'b1;
            a_in     = 32'h40400000;
        end
        @(posedge clk_in);
        #1;
        rst_in   = 1'b0;
        valid_in = 1'b1;
        a_in     = 32'h40800000;
        @(posedge clk_in);
        #1;
        check("flush_valid", {31'b0, valid_out}, 32'd0);
        check("flush_fixed", fixed_out, 32'h0);
        rst_in   = 1'b1;
        valid_in = 1'b1;
        a_in     = 32'h41200000;
        push_exp(32'h000A0000, 1'b0);
        idle(8);

        check("drain", 32'(exp_q.size()), 32'd0);
        check("hold", fixed_out, last_f);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
